axi4_slave_mem: RTL and testbench
=================================

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of AWADDR/ARADDR.
REQ-002 Parameter DATA_WIDTH, default 32, data bus width; SHALL be 32, 64 or 128.
REQ-003 Parameter ID_WIDTH, default 9, width of AWID/BID/ARID/RID.
REQ-004 Parameter MEM_DEPTH, default 1024, storage depth in DATA_WIDTH words; SHALL be a power of two.
REQ-005 Ports: clk in 1, sole clock; rst in 1, synchronous active-high reset. One clock; reset is synchronous and active-high.
REQ-006 Write address: AWID in ID_WIDTH; AWADDR in ADDR_WIDTH; AWLEN in 8, beats-1; AWSIZE in 3; AWBURST in 2; AWVALID in 1; AWREADY out 1.
REQ-007 Write data: WDATA in DATA_WIDTH; WSTRB in DATA_WIDTH/8; WLAST in 1; WVALID in 1; WREADY out 1 (no WID).
REQ-008 Write response: BID out ID_WIDTH; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-009 Read address: ARID, ARADDR, ARLEN (8), ARSIZE, ARBURST, ARVALID in; ARREADY out 1.
REQ-010 Read data: RID out ID_WIDTH; RDATA out DATA_WIDTH; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.

Function
REQ-011 Write FSM states W_IDLE, W_DATA, W_RESP; read FSM states R_IDLE, R_DATA; the two SHALL operate independently and concurrently.
REQ-012 W_IDLE: AWREADY=1; on AWVALID latch AWID/AWADDR/AWLEN/AWSIZE/AWBURST, zero beat counter, go W_DATA next cycle.
REQ-013 W_DATA: WREADY=1, AWREADY=0; each WVALID&&WREADY beat writes byte lanes with WSTRB[i]=1 only; unstrobed bytes unchanged.
REQ-014 Burst terminates on beat AWLEN+1 regardless of WLAST; then W_RESP with BVALID=1, BID=latched AWID.
REQ-015 BRESP=OKAY (2'b00) unless REQ-026 applies, or WLAST disagrees with final-beat position on any beat (then SLVERR 2'b10).
REQ-016 W_RESP: hold BID/BRESP/BVALID stable until BREADY; on BVALID&&BREADY return to W_IDLE; AWREADY re-asserts next cycle.
REQ-017 R_IDLE: ARREADY=1; on ARVALID latch AR fields, go R_DATA; first RVALID exactly one cycle after the AR handshake.
REQ-018 R_DATA: ARREADY=0; RDATA = word at current address; RID = latched ARID; RLAST=1 only on beat ARLEN+1; outputs held stable while RVALID&&!RREADY.
REQ-019 On RVALID&&RREADY&&RLAST go R_IDLE with RVALID=0 next cycle; otherwise advance to next beat with RVALID staying 1 (zero-bubble).
REQ-020 Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH.
REQ-021 FIXED (2'b00): address constant. INCR (2'b01): address += 2^SIZE bytes per beat. Reserved 2'b11 treated as INCR.
REQ-022 WRAP (2'b10): wrap boundary = (LEN+1)*2^SIZE, aligned; legal only for LEN in {1,3,7,15}; otherwise treated as INCR.
REQ-023 SIZE greater than log2(DATA_WIDTH/8) treated as full bus width.
REQ-024 Read and write to the same word in the same cycle: read returns pre-write contents.

Reset
REQ-025 While rst=1 at a clk edge: both FSMs to IDLE; AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0; BID, BRESP, RID, RDATA, RRESP=0; in-flight bursts abandoned; memory contents not cleared; AWREADY/ARREADY=1 on first cycle after rst deasserts.

Configuration
REQ-026 Macro AXI4_SLV_RANGE_CHECK_EN defined: any beat whose word index >= MEM_DEPTH (before modulo) is not written/read; RDATA=0, RRESP=SLVERR for that beat; BRESP=SLVERR for that write burst. Undefined: addresses wrap modulo MEM_DEPTH, range-based responses always OKAY.

Verification
REQ-027 AW INCR addr 0x100, LEN 3, SIZE 2, data 0x11..0x44, BREADY=1 -> BVALID one cycle after 4th beat, BID=AWID, BRESP=00; read back same -> 0x11,0x22,0x33,0x44, RLAST on beat 4.
REQ-028 WRAP addr 0x108, LEN 3, SIZE 2 -> beats hit 0x108,0x10C,0x100,0x104.
REQ-029 Write 0xFFFFFFFF then 0x00000000 with WSTRB 4'b0101 -> read 0xFF00FF00.
REQ-030 RREADY low 3 cycles mid-burst -> RDATA/RID/RLAST stable, no beat lost; BREADY low 5 cycles -> BVALID/BID held.
REQ-031 rst asserted in W_DATA after 2 of 8 beats -> all valids 0 next cycle, new AW accepted after release, 2 written words retained.
REQ-032 With AXI4_SLV_RANGE_CHECK_EN, read addr MEM_DEPTH*4 LEN 0 -> RRESP=10, RDATA=0; write WLAST early on beat 2 of 4 -> BRESP=10.

Source files
------------

// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle between a master and the axi4_slave_mem target.
// No logic: wires only, grouped per channel.
// Flow control: standard AXI VALID/READY on every channel.
interface axi4_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 9
);
    // write address channel
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    // write data channel
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    // write response channel
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    // read address channel
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    // read data channel
    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 burst memory target with independent write (AW/W/B) and read (AR/R) engines.
// Latency: B one cycle after the final W beat; first R beat one cycle after AR, then one beat per cycle.
// Backpressure: B and R outputs hold while READY is low; optional AXI4_SLV_RANGE_CHECK_EN rejects beats beyond MEM_DEPTH.
module axi4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 9,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    axi4_slave_mem_if.slave bus
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int LANE_LOG2 = $clog2(STRB_W);
    localparam int IDX_W     = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Storage is never reset so contents survive a bus reset.
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Address of the beat following addr; oversized SIZE is clamped to the bus width,
    // WRAP with an illegal length and the reserved encoding both step like INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [2:0]            eff_size;
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] wrap_mask;
        logic                  wrap_ok;
        eff_size  = (size > 3'(LANE_LOG2)) ? 3'(LANE_LOG2) : size;
        step      = ADDR_WIDTH'(1) << eff_size;
        wrap_ok   = (burst == BURST_WRAP) &&
                    (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << eff_size) - ADDR_WIDTH'(1);
        if (burst == BURST_FIXED) begin
            return addr;
        end else if (wrap_ok) begin
            return (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
        end else begin
            return addr + step;
        end
    endfunction

    // Word index wraps modulo MEM_DEPTH by truncation.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(addr >> LANE_LOG2);
    endfunction

`ifdef AXI4_SLV_RANGE_CHECK_EN
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> LANE_LOG2) >= ADDR_WIDTH'(MEM_DEPTH);
    endfunction
`endif

    // ---------------------------------------------------------------- write side
    w_state_t              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [7:0]            aw_len_q;
    logic [2:0]            aw_size_q;
    logic [1:0]            aw_burst_q;
    logic [7:0]            w_cnt_q;
    logic                  w_err_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [1:0]            bresp_q;
    logic                  aw_rdy, w_rdy, b_vld;
    logic                  aw_hs, w_hs;
    logic                  w_beat_last, w_beat_err, w_oob;

`ifdef AXI4_SLV_RANGE_CHECK_EN
    assign w_oob = out_of_range(aw_addr_q);
`else
    assign w_oob = 1'b0;
`endif

    assign w_beat_last = (w_cnt_q == aw_len_q);
    // A WLAST that disagrees with the beat count flags the burst but never shortens it.
    assign w_beat_err  = (bus.WLAST != w_beat_last) || w_oob;
    assign aw_hs       = aw_rdy && bus.AWVALID && !rst;
    assign w_hs        = w_rdy && bus.WVALID && !rst;

    // Write FSM next state and channel ready/valid decode.
    always_comb begin
        w_state_d = w_state_q;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        b_vld     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_rdy = 1'b1;
                if (bus.AWVALID) w_state_d = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (bus.WVALID && w_beat_last) w_state_d = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (bus.BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) w_state_q <= W_IDLE;
        else     w_state_q <= w_state_d;
    end

    // Write burst context, beat counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_addr_q  <= bus.AWADDR;
                aw_id_q    <= bus.AWID;
                aw_len_q   <= bus.AWLEN;
                aw_size_q  <= bus.AWSIZE;
                aw_burst_q <= bus.AWBURST;
                w_cnt_q    <= '0;
                w_err_q    <= 1'b0;
            end
            if (w_hs) begin
                aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                w_cnt_q   <= w_cnt_q + 8'd1;
                w_err_q   <= w_err_q || w_beat_err;
                if (w_beat_last) begin
                    bid_q   <= aw_id_q;
                    bresp_q <= (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Byte-lane write of accepted beats; unstrobed lanes keep their contents.
    always_ff @(posedge clk) begin
        if (w_hs && !w_oob) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (bus.WSTRB[i]) mem_q[word_idx(aw_addr_q)][i*8 +: 8] <= bus.WDATA[i*8 +: 8];
            end
        end
    end

    assign bus.AWREADY = aw_rdy && !rst;
    assign bus.WREADY  = w_rdy;
    assign bus.BVALID  = b_vld;
    assign bus.BID     = bid_q;
    assign bus.BRESP   = bresp_q;

    // ----------------------------------------------------------------- read side
    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]            ar_len_q;
    logic [2:0]            ar_size_q;
    logic [1:0]            ar_burst_q;
    logic [7:0]            r_cnt_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic                  ar_rdy, r_vld;
    logic                  ar_hs, r_hs;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic                  ar_oob, r_next_oob;

    assign r_next_addr = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);

`ifdef AXI4_SLV_RANGE_CHECK_EN
    assign ar_oob     = out_of_range(bus.ARADDR);
    assign r_next_oob = out_of_range(r_next_addr);
`else
    assign ar_oob     = 1'b0;
    assign r_next_oob = 1'b0;
`endif

    assign ar_hs = ar_rdy && bus.ARVALID && !rst;
    assign r_hs  = r_vld && bus.RREADY && !rst;

    // Read FSM next state and channel ready/valid decode.
    always_comb begin
        r_state_d = r_state_q;
        ar_rdy    = 1'b0;
        r_vld     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (bus.ARVALID) r_state_d = R_DATA;
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (bus.RREADY && rlast_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state_q <= R_IDLE;
        else     r_state_q <= r_state_d;
    end

    // Read beat pipeline: the word is fetched on the edge that accepts AR or the
    // previous beat, so a same-cycle write to that word is seen only by later reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else if (ar_hs) begin
            ar_addr_q  <= bus.ARADDR;
            ar_len_q   <= bus.ARLEN;
            ar_size_q  <= bus.ARSIZE;
            ar_burst_q <= bus.ARBURST;
            r_cnt_q    <= '0;
            rid_q      <= bus.ARID;
            rlast_q    <= (bus.ARLEN == 8'd0);
            rdata_q    <= ar_oob ? '0 : mem_q[word_idx(bus.ARADDR)];
            rresp_q    <= ar_oob ? RESP_SLVERR : RESP_OKAY;
        end else if (r_hs) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                ar_addr_q <= r_next_addr;
                r_cnt_q   <= r_cnt_q + 8'd1;
                rlast_q   <= ((r_cnt_q + 8'd1) == ar_len_q);
                rdata_q   <= r_next_oob ? '0 : mem_q[word_idx(r_next_addr)];
                rresp_q   <= r_next_oob ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign bus.ARREADY = ar_rdy && !rst;
    assign bus.RVALID  = r_vld;
    assign bus.RID     = rid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RLAST   = rlast_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, strobes, WRAP/FIXED, stalls, reset, range.
// Inputs driven 1ns after each rising edge, outputs sampled at the same point.
// Every wait on the DUT is bounded; an expired bound counts as a failure.
module tb_axi4_slave_mem;
    logic clk;
    logic rst;

    axi4_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9)) bus_if ();

    axi4_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9), .MEM_DEPTH(1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic [31:0] rexp [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ch: 0 = AW, 1 = W, 2 = AR. Returns just after the accepting edge.
    task automatic handshake(input string tag, input int ch);
        bit hs = 1'b0;
        int n  = 0;
        while (!hs && n < 20) begin
            case (ch)
                0:       hs = bus_if.AWREADY;
                1:       hs = bus_if.WREADY;
                default: hs = bus_if.ARREADY;
            endcase
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_handshake"}, 64'(hs), 64'd1);
    endtask

    task automatic write_burst(input string tag, input logic [8:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                               input int last_idx, input int b_delay, input logic [1:0] exp_resp);
        bus_if.AWID = id; bus_if.AWADDR = addr; bus_if.AWLEN = len;
        bus_if.AWSIZE = size; bus_if.AWBURST = burst; bus_if.AWVALID = 1'b1;
        handshake({tag, "_aw"}, 0);
        bus_if.AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus_if.WDATA = wdat[i]; bus_if.WSTRB = wstb[i];
            bus_if.WLAST = (i == last_idx); bus_if.WVALID = 1'b1;
            handshake($sformatf("%s_w%0d", tag, i), 1);
        end
        bus_if.WVALID = 1'b0; bus_if.WLAST = 1'b0;
        check({tag, "_bvalid"}, 64'(bus_if.BVALID), 64'd1);
        check({tag, "_bid"},    64'(bus_if.BID),    64'(id));
        check({tag, "_bresp"},  64'(bus_if.BRESP),  64'(exp_resp));
        repeat (b_delay) begin
            @(posedge clk); #1;
            check({tag, "_bhold"}, {bus_if.BVALID, bus_if.BID, bus_if.BRESP}, {1'b1, id, exp_resp});
        end
        bus_if.BREADY = 1'b1;
        @(posedge clk); #1;
        bus_if.BREADY = 1'b0;
        check({tag, "_bdone"}, {bus_if.BVALID, bus_if.AWREADY}, 2'b01);
    endtask

    task automatic read_burst(input string tag, input logic [8:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input int stall_beat, input logic [1:0] exp_resp);
        bus_if.ARID = id; bus_if.ARADDR = addr; bus_if.ARLEN = len;
        bus_if.ARSIZE = size; bus_if.ARBURST = burst; bus_if.ARVALID = 1'b1;
        handshake({tag, "_ar"}, 2);
        bus_if.ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall_beat) begin
                repeat (3) begin
                    @(posedge clk); #1;
                    check($sformatf("%s_stall%0d", tag, i),
                          {bus_if.RVALID, bus_if.RLAST, bus_if.RID, bus_if.RDATA},
                          {1'b1, (i == int'(len)), id, rexp[i]});
                end
            end
            check($sformatf("%s_rvalid%0d", tag, i), 64'(bus_if.RVALID), 64'd1);
            check($sformatf("%s_rdata%0d", tag, i),  64'(bus_if.RDATA),  64'(rexp[i]));
            check($sformatf("%s_rmeta%0d", tag, i), {bus_if.RLAST, bus_if.RID, bus_if.RRESP},
                  {(i == int'(len)), id, exp_resp});
            bus_if.RREADY = 1'b1;
            @(posedge clk); #1;
            bus_if.RREADY = 1'b0;
        end
        check({tag, "_rdone"}, {bus_if.RVALID, bus_if.ARREADY}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_if.AWID = '0; bus_if.AWADDR = '0; bus_if.AWLEN = '0; bus_if.AWSIZE = '0;
        bus_if.AWBURST = '0; bus_if.AWVALID = 1'b0;
        bus_if.WDATA = '0; bus_if.WSTRB = '0; bus_if.WLAST = 1'b0; bus_if.WVALID = 1'b0;
        bus_if.BREADY = 1'b0;
        bus_if.ARID = '0; bus_if.ARADDR = '0; bus_if.ARLEN = '0; bus_if.ARSIZE = '0;
        bus_if.ARBURST = '0; bus_if.ARVALID = 1'b0; bus_if.RREADY = 1'b0;
        for (int i = 0; i < 16; i++) begin wdat[i] = '0; wstb[i] = 4'hF; rexp[i] = '0; end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valids", {bus_if.AWREADY, bus_if.WREADY, bus_if.BVALID,
                             bus_if.ARREADY, bus_if.RVALID, bus_if.RLAST}, 6'b0);
        check("rst_ids", {bus_if.BID, bus_if.BRESP, bus_if.RID, bus_if.RRESP}, 22'b0);
        check("rst_rdata", 64'(bus_if.RDATA), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", {bus_if.AWREADY, bus_if.ARREADY}, 2'b11);
        @(posedge clk); #1;

        // INCR write and read-back
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        write_burst("incr_wr", 9'h1A5, 32'h100, 8'd3, 3'd2, 2'b01, 3, 0, 2'b00);
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        read_burst("incr_rd", 9'h0C3, 32'h100, 8'd3, 3'd2, 2'b01, -1, 2'b00);

        // WRAP write lands on 0x108,0x10C,0x100,0x104
        wdat[0] = 32'hA1; wdat[1] = 32'hA2; wdat[2] = 32'hA3; wdat[3] = 32'hA4;
        write_burst("wrap_wr", 9'h002, 32'h108, 8'd3, 3'd2, 2'b10, 3, 0, 2'b00);
        rexp[0] = 32'hA3; rexp[1] = 32'hA4; rexp[2] = 32'hA1; rexp[3] = 32'hA2;
        read_burst("wrap_chk", 9'h003, 32'h100, 8'd3, 3'd2, 2'b01, -1, 2'b00);
        // WRAP read with a 3-cycle RREADY stall on beat 1
        rexp[0] = 32'hA1; rexp[1] = 32'hA2; rexp[2] = 32'hA3; rexp[3] = 32'hA4;
        read_burst("wrap_rd_stall", 9'h104, 32'h108, 8'd3, 3'd2, 2'b10, 1, 2'b00);

        // byte strobes, second write holds B for 5 cycles
        wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
        write_burst("strb_wr1", 9'h010, 32'h200, 8'd0, 3'd2, 2'b01, 0, 0, 2'b00);
        wdat[0] = 32'h0000_0000; wstb[0] = 4'b0101;
        write_burst("strb_wr2", 9'h155, 32'h200, 8'd0, 3'd2, 2'b01, 0, 5, 2'b00);
        wstb[0] = 4'hF;
        rexp[0] = 32'hFF00_FF00;
        read_burst("strb_rd", 9'h011, 32'h200, 8'd0, 3'd2, 2'b01, -1, 2'b00);

        // WLAST early on beat 2 of 4: full burst still written, SLVERR
        wdat[0] = 32'h1; wdat[1] = 32'h2; wdat[2] = 32'h3; wdat[3] = 32'h4;
        write_burst("wlast_early", 9'h020, 32'h400, 8'd3, 3'd2, 2'b01, 1, 0, 2'b10);
        rexp[0] = 32'h1; rexp[1] = 32'h2; rexp[2] = 32'h3; rexp[3] = 32'h4;
        read_burst("wlast_early_rd", 9'h021, 32'h400, 8'd3, 3'd2, 2'b01, -1, 2'b00);
        // WLAST never asserted
        write_burst("wlast_missing", 9'h022, 32'h440, 8'd1, 3'd2, 2'b01, -1, 0, 2'b10);

        // SIZE above bus width steps by 4 bytes
        wdat[0] = 32'hC1; wdat[1] = 32'hC2;
        write_burst("size_big_wr", 9'h030, 32'h500, 8'd1, 3'd3, 2'b01, 1, 0, 2'b00);
        rexp[0] = 32'hC1; rexp[1] = 32'hC2;
        read_burst("size_big_rd", 9'h031, 32'h500, 8'd1, 3'd2, 2'b01, -1, 2'b00);
        // reserved burst type behaves as INCR
        read_burst("rsvd_rd", 9'h032, 32'h500, 8'd1, 3'd2, 2'b11, -1, 2'b00);
        // WRAP with illegal length behaves as INCR: 0x104,0x108,0x10C
        rexp[0] = 32'hA4; rexp[1] = 32'hA1; rexp[2] = 32'hA2;
        read_burst("wrap_bad_len", 9'h033, 32'h104, 8'd2, 3'd2, 2'b10, -1, 2'b00);

        // FIXED burst: every beat hits 0x300
        wdat[0] = 32'hD1; wdat[1] = 32'hD2; wdat[2] = 32'hD3;
        write_burst("fixed_wr", 9'h040, 32'h300, 8'd2, 3'd2, 2'b00, 2, 0, 2'b00);
        rexp[0] = 32'hD3; rexp[1] = 32'hD3; rexp[2] = 32'hD3;
        read_burst("fixed_rd", 9'h041, 32'h300, 8'd2, 3'd2, 2'b00, -1, 2'b00);

        // read and write of the same word on the same edge: read sees old data
        wdat[0] = 32'h1234_5678;
        write_burst("rw_pre", 9'h050, 32'h800, 8'd0, 3'd2, 2'b01, 0, 0, 2'b00);
        bus_if.AWID = 9'h051; bus_if.AWADDR = 32'h800; bus_if.AWLEN = 8'd0;
        bus_if.AWSIZE = 3'd2; bus_if.AWBURST = 2'b01; bus_if.AWVALID = 1'b1;
        handshake("rw_aw", 0);
        bus_if.AWVALID = 1'b0;
        bus_if.WDATA = 32'h9ABC_DEF0; bus_if.WSTRB = 4'hF; bus_if.WLAST = 1'b1; bus_if.WVALID = 1'b1;
        bus_if.ARID = 9'h052; bus_if.ARADDR = 32'h800; bus_if.ARLEN = 8'd0;
        bus_if.ARSIZE = 3'd2; bus_if.ARBURST = 2'b01; bus_if.ARVALID = 1'b1;
        check("rw_ready", {bus_if.WREADY, bus_if.ARREADY}, 2'b11);
        @(posedge clk); #1;
        bus_if.WVALID = 1'b0; bus_if.WLAST = 1'b0; bus_if.ARVALID = 1'b0;
        check("rw_valids", {bus_if.BVALID, bus_if.RVALID}, 2'b11);
        check("rw_old_data", 64'(bus_if.RDATA), 64'h1234_5678);
        bus_if.BREADY = 1'b1; bus_if.RREADY = 1'b1;
        @(posedge clk); #1;
        bus_if.BREADY = 1'b0; bus_if.RREADY = 1'b0;
        check("rw_done", {bus_if.BVALID, bus_if.RVALID}, 2'b00);
        rexp[0] = 32'h9ABC_DEF0;
        read_burst("rw_new", 9'h053, 32'h800, 8'd0, 3'd2, 2'b01, -1, 2'b00);

        // reset after 2 of 8 beats
        bus_if.AWID = 9'h077; bus_if.AWADDR = 32'h600; bus_if.AWLEN = 8'd7;
        bus_if.AWSIZE = 3'd2; bus_if.AWBURST = 2'b01; bus_if.AWVALID = 1'b1;
        handshake("rstmid_aw", 0);
        bus_if.AWVALID = 1'b0;
        bus_if.WDATA = 32'hB1; bus_if.WSTRB = 4'hF; bus_if.WLAST = 1'b0; bus_if.WVALID = 1'b1;
        handshake("rstmid_w0", 1);
        bus_if.WDATA = 32'hB2;
        handshake("rstmid_w1", 1);
        bus_if.WVALID = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_valids", {bus_if.AWREADY, bus_if.WREADY, bus_if.BVALID,
                                bus_if.ARREADY, bus_if.RVALID, bus_if.RLAST}, 6'b0);
        rst = 1'b0;
        #1;
        check("rstmid_release", {bus_if.AWREADY, bus_if.ARREADY}, 2'b11);
        wdat[0] = 32'hE1;
        write_burst("rstmid_new", 9'h078, 32'h700, 8'd0, 3'd2, 2'b01, 0, 0, 2'b00);
        rexp[0] = 32'hB1; rexp[1] = 32'hB2;
        read_burst("rstmid_kept", 9'h079, 32'h600, 8'd1, 3'd2, 2'b01, -1, 2'b00);

        // address MEM_DEPTH*4
        wdat[0] = 32'hCAFE_0001;
        write_burst("range_base", 9'h060, 32'h0, 8'd0, 3'd2, 2'b01, 0, 0, 2'b00);
        wdat[0] = 32'hDEAD_0002;
`ifdef AXI4_SLV_RANGE_CHECK_EN
        write_burst("range_wr", 9'h061, 32'h1000, 8'd0, 3'd2, 2'b01, 0, 0, 2'b10);
        rexp[0] = 32'hCAFE_0001;
        read_burst("range_base_rd", 9'h062, 32'h0, 8'd0, 3'd2, 2'b01, -1, 2'b00);
        rexp[0] = 32'h0;
        read_burst("range_rd", 9'h063, 32'h1000, 8'd0, 3'd2, 2'b01, -1, 2'b10);
`else
        write_burst("range_wr", 9'h061, 32'h1000, 8'd0, 3'd2, 2'b01, 0, 0, 2'b00);
        rexp[0] = 32'hDEAD_0002;
        read_burst("range_base_rd", 9'h062, 32'h0, 8'd0, 3'd2, 2'b01, -1, 2'b00);
        read_burst("range_rd", 9'h063, 32'h1000, 8'd0, 3'd2, 2'b01, -1, 2'b00);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
